psum_shift_accumulator: RTL and testbench
=========================================

Name: psum_shift_accumulator

Overview:
- Sits directly downstream of the PE array row and consumes the registered, signed partial sum each PE produces every cycle.
- Sign-extends and left-shifts each partial sum by a per-beat bit-significance amount, then adds it into a wide accumulator. This recombines bit-slice passes and input-channel tiles into one output-activation sum.
- Accumulation groups are delimited by a last-beat marker.
- Each finished sum goes into a one-entry output register with a valid/ready handshake toward the output/quantisation stage.

Parameters:
- BITS_IN, 12: width of incoming signed partial sum; equals the PE psum width.
- BITS_ACC, 24: accumulator and result width, signed.
- BITS_SHIFT, 3: width of per-beat shift amount; shift range 0..7.
- CNT_W, 6: beat counter width; at most 2^CNT_W-1 beats per group.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- i_Valid  in  1  partial-sum beat present.
- i_PSUM  in  BITS_IN  signed partial sum from the PE.
- i_Shift  in  BITS_SHIFT  left-shift applied to this beat.
- i_Last  in  1  this beat closes the accumulation group.
- i_Clear  in  1  discard the in-progress accumulation.
- o_Ready  out  1  beat accepted this cycle if i_Valid is high.
- o_Valid  out  1  result register holds an unconsumed result.
- i_Ready  in  1  downstream consumes the result this cycle.
- o_Acc  out  BITS_ACC  signed accumulated result.
- o_Count  out  CNT_W  number of beats in the result on o_Acc.
- o_Err  out  1  sticky beat-counter overflow flag.
- o_Sat  out  1  result saturated; see Optional Feature.

Behaviour:
- Reset (RST=1 at a clock edge): acc=0, cnt=0, state=IDLE, o_Valid=0, o_Acc=0, o_Count=0, o_Err=0, o_Sat=0.
  - Reset mid-group discards the group.
  - Reset with o_Valid=1 drops the pending result.
- Accept: a beat is accepted when i_Valid && o_Ready.
  - o_Ready = !(o_Valid && !i_Ready). This is purely from registered state plus i_Ready, with no path from i_Valid.
  - A beat is accepted in the same cycle the held result drains.
- Term: the beat's contribution is sign_extend(i_PSUM, BITS_ACC) << i_Shift, computed in BITS_ACC bits.
  - sum = (state==IDLE ? 0 : acc) + term.
- State IDLE (no beats accumulated):
  - Accepted beat with !i_Last: acc<=sum, cnt<=1, go to ACCUM.
  - Accepted beat with i_Last: single-beat group; the result is loaded as described under Completion.
- State ACCUM:
  - Accepted beat with !i_Last: acc<=sum, cnt<=cnt+1.
  - Accepted beat with i_Last: the group is complete.
- Completion:
  - o_Acc<=sum, o_Count<=cnt+1, o_Valid<=1, acc<=0, cnt<=0, go to IDLE.
  - Latency: result visible exactly 1 cycle after the last beat's accepting edge.
- Drain: with o_Valid && i_Ready and no completing beat in the same cycle, o_Valid<=0. o_Acc holds its last value.
  - With a simultaneous drain and completing beat, o_Valid stays 1 and the new result replaces the old one.
- Clear: i_Clear=1 forces acc<=0, cnt<=0, state IDLE.
  - i_Clear has priority over any beat that cycle; that beat is dropped even if handshaked.
  - i_Clear does not affect the output register, o_Valid or o_Err.
- Counter overflow: an accepted non-last beat with cnt==2^CNT_W-1 sets o_Err=1 (sticky until RST).
  - cnt saturates at 2^CNT_W-1.
  - Accumulation continues.
- While o_Ready=0, input is ignored and acc/cnt hold.

Optional Feature:
- Macro: PSUM_ACC_SAT_EN.
- Defined:
  - The addition saturates to [-2^(BITS_ACC-1), 2^(BITS_ACC-1)-1].
  - An internal sticky bit records any saturation within the group.
  - o_Sat is loaded with that bit alongside o_Acc and clears at group start.
- Undefined:
  - Two's-complement wrap-around.
  - o_Sat is tied to 0.

Test Plan:
- Reset: hold RST 2 cycles during random input -> o_Valid=0, o_Acc=0, o_Count=0, o_Ready=1, o_Err=0.
- Basic group: send beats (5,sh0), (-3,sh1), (7,sh2,last) with i_Ready=1 -> one cycle after the last beat, o_Valid=1, o_Acc=27, o_Count=3; o_Valid=0 the next cycle.
- Backpressure: hold i_Ready=0 with a result pending while the next group's last beat is presented -> o_Ready=0, beat not taken, o_Acc unchanged. Then raise i_Ready -> beat accepted that cycle, and the new result appears on the next cycle with o_Valid still 1.
- Single-beat group: send (-2048, sh7, last) -> o_Acc=-262144, o_Count=1.
- Clear mid-group: send beats 100 and 200, then i_Clear, then (4, sh0, last) -> o_Acc=4, o_Count=1.
- Overflow: send 33 beats of (2047, sh7), the last one flagged last.
  - With PSUM_ACC_SAT_EN: o_Acc=8388607, o_Sat=1.
  - Without it: o_Acc=-8130688, o_Sat=0.
  - Separately, 64 non-last beats -> o_Err=1.

Source files
------------

// File: rtl/psum_shift_accumulator.sv
// psum_shift_accumulator
//   Recombines bit-slice / channel-tile partial sums from a PE row into one
//   wide signed output-activation sum. Each accepted beat is sign-extended,
//   shifted left by its bit significance and added to the running group
//   accumulator. The beat flagged i_Last closes the group, and the finished
//   sum is loaded into a one-entry valid/ready output register.
//
// Optional feature macro: PSUM_ACC_SAT_EN
//   defined   : additions saturate to the signed BITS_ACC range and o_Sat
//               reports whether any addition in the group saturated
//   undefined : two's-complement wrap-around, o_Sat tied to 0
//
// Ports
//   CLK, RST   rising-edge clock, synchronous active-high reset
//   i_Valid    partial-sum beat present
//   i_PSUM     signed partial sum (BITS_IN)
//   i_Shift    left shift for this beat (BITS_SHIFT)
//   i_Last     beat closes the accumulation group
//   i_Clear    discard the in-progress group (beat of this cycle dropped)
//   o_Ready    beat accepted this cycle when i_Valid is high
//   o_Valid    output register holds an unconsumed result
//   i_Ready    downstream consumes the result this cycle
//   o_Acc      signed accumulated result (BITS_ACC)
//   o_Count    number of beats in the result on o_Acc (CNT_W)
//   o_Err      sticky beat-counter overflow
//   o_Sat      result saturated (0 unless PSUM_ACC_SAT_EN)
module psum_shift_accumulator #(
  parameter int BITS_IN    = 12,
  parameter int BITS_ACC   = 24,
  parameter int BITS_SHIFT = 3,
  parameter int CNT_W      = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_Valid,
  input  logic [BITS_IN-1:0]    i_PSUM,
  input  logic [BITS_SHIFT-1:0] i_Shift,
  input  logic                  i_Last,
  input  logic                  i_Clear,
  output logic                  o_Ready,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic [BITS_ACC-1:0]   o_Acc,
  output logic [CNT_W-1:0]      o_Count,
  output logic                  o_Err,
  output logic                  o_Sat
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                      r_state, w_state_next;
  logic signed [BITS_ACC-1:0]  r_acc, w_acc_next;
  logic [CNT_W-1:0]            r_cnt, w_cnt_next;
  logic signed [BITS_ACC-1:0]  r_out, w_out_next;
  logic [CNT_W-1:0]            r_count_out, w_count_out_next;
  logic                        r_valid, w_valid_next;
  logic                        r_err, w_err_next;

  logic                        w_ready;
  logic                        w_take;
  logic signed [BITS_ACC-1:0]  w_ext;
  logic signed [BITS_ACC-1:0]  w_term;
  logic signed [BITS_ACC-1:0]  w_base;
  logic signed [BITS_ACC-1:0]  w_sum;
  logic [CNT_W-1:0]            w_cnt_inc;

  // Ready depends only on the output register and downstream ready, so a
  // beat can enter in the same cycle the held result drains.
  assign w_ready = !(r_valid && !i_Ready);
  assign w_take  = i_Valid && w_ready;

  assign w_ext  = {{(BITS_ACC-BITS_IN){i_PSUM[BITS_IN-1]}}, i_PSUM};
  assign w_term = w_ext << i_Shift;
  assign w_base = (r_state == IDLE) ? '0 : r_acc;

  // Beat count saturates; the overflow is reported through o_Err instead.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;

`ifdef PSUM_ACC_SAT_EN
  localparam logic signed [BITS_ACC-1:0] ACC_MAX = {1'b0, {(BITS_ACC-1){1'b1}}};
  localparam logic signed [BITS_ACC-1:0] ACC_MIN = {1'b1, {(BITS_ACC-1){1'b0}}};

  logic signed [BITS_ACC:0] w_wide;
  logic                     w_ovf;
  logic                     w_grp_sat;
  logic                     r_sat_grp;
  logic                     r_sat_out;

  // One extra bit exposes signed overflow; the top bit gives its direction.
  assign w_wide    = {w_base[BITS_ACC-1], w_base} + {w_term[BITS_ACC-1], w_term};
  assign w_ovf     = w_wide[BITS_ACC] != w_wide[BITS_ACC-1];
  assign w_sum     = w_ovf ? (w_wide[BITS_ACC] ? ACC_MIN : ACC_MAX) : w_wide[BITS_ACC-1:0];
  assign w_grp_sat = ((r_state == IDLE) ? 1'b0 : r_sat_grp) | w_ovf;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sat_grp <= 1'b0;
      r_sat_out <= 1'b0;
    end else if (i_Clear) begin
      r_sat_grp <= 1'b0;
    end else if (w_take) begin
      if (i_Last) begin
        r_sat_out <= w_grp_sat;
        r_sat_grp <= 1'b0;
      end else begin
        r_sat_grp <= w_grp_sat;
      end
    end
  end

  assign o_Sat = r_sat_out;
`else
  assign w_sum = w_base + w_term;
  assign o_Sat = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_cnt_next       = r_cnt;
    w_out_next       = r_out;
    w_count_out_next = r_count_out;
    w_valid_next     = r_valid;
    w_err_next       = r_err;

    if (r_valid && i_Ready) begin
      w_valid_next = 1'b0;
    end

    if (i_Clear) begin
      // Clear wins over any beat this cycle; the output side is untouched.
      w_acc_next   = '0;
      w_cnt_next   = '0;
      w_state_next = IDLE;
    end else if (w_take) begin
      if (i_Last) begin
        // A completing beat overrides a same-cycle drain.
        w_out_next       = w_sum;
        w_count_out_next = w_cnt_inc;
        w_valid_next     = 1'b1;
        w_acc_next       = '0;
        w_cnt_next       = '0;
        w_state_next     = IDLE;
      end else begin
        w_acc_next   = w_sum;
        w_cnt_next   = w_cnt_inc;
        w_state_next = ACCUM;
        if (r_cnt == CNT_MAX) begin
          w_err_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_count_out <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_cnt       <= w_cnt_next;
      r_out       <= w_out_next;
      r_count_out <= w_count_out_next;
      r_valid     <= w_valid_next;
      r_err       <= w_err_next;
    end
  end

  assign o_Ready = w_ready;
  assign o_Valid = r_valid;
  assign o_Acc   = r_out;
  assign o_Count = r_count_out;
  assign o_Err   = r_err;

endmodule

// File: tb/tb_psum_shift_accumulator.sv
// Testbench for psum_shift_accumulator: directed cases with literal
// expectations followed by randomized traffic, all checked every cycle
// against a queue-based behavioural model of the accumulation groups.
module tb_psum_shift_accumulator;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               i_Valid = 1'b0;
  logic [11:0]        i_PSUM = '0;
  logic [2:0]         i_Shift = '0;
  logic               i_Last = 1'b0;
  logic               i_Clear = 1'b0;
  logic               i_Ready = 1'b0;
  logic               o_Ready;
  logic               o_Valid;
  logic signed [23:0] o_Acc;
  logic [5:0]         o_Count;
  logic               o_Err;
  logic               o_Sat;

  psum_shift_accumulator dut (
    .CLK     (CLK),
    .RST     (RST),
    .i_Valid (i_Valid),
    .i_PSUM  (i_PSUM),
    .i_Shift (i_Shift),
    .i_Last  (i_Last),
    .i_Clear (i_Clear),
    .o_Ready (o_Ready),
    .o_Valid (o_Valid),
    .i_Ready (i_Ready),
    .o_Acc   (o_Acc),
    .o_Count (o_Count),
    .o_Err   (o_Err),
    .o_Sat   (o_Sat)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The open group is a queue of beat terms; a result is produced by summing
  // the queue when the last beat arrives.
  localparam longint ACC_MAX = 64'sd8388607;
  localparam longint ACC_MIN = -64'sd8388608;

  longint q[$];
  bit     m_valid = 1'b0;
  bit     m_err   = 1'b0;
  bit     m_sat   = 1'b0;
  longint m_acc   = 0;
  longint m_cnt   = 0;
  bit     started = 1'b0;

  function automatic longint wrap24(input longint s);
    longint r;
    r = (s - ACC_MIN) % 64'sd16777216;
    if (r < 0) r += 64'sd16777216;
    return r + ACC_MIN;
  endfunction

  always @(posedge CLK) begin
    bit     rdy, take;
    longint t, s;
    bit     sat;
    started = 1'b1;
    if (RST) begin
      q.delete();
      m_valid = 0; m_err = 0; m_sat = 0; m_acc = 0; m_cnt = 0;
    end else begin
      rdy  = !(m_valid && !i_Ready);
      take = i_Valid && rdy && !i_Clear;
      if (m_valid && i_Ready) m_valid = 0;
      if (i_Clear) begin
        q.delete();
      end else if (take) begin
        t = longint'($signed(i_PSUM)) * (64'sd1 << i_Shift);
        if (!i_Last) begin
          if (q.size() >= 63) m_err = 1;
          q.push_back(t);
        end else begin
          q.push_back(t);
          s = 0;
          sat = 0;
          foreach (q[k]) begin
            s += q[k];
`ifdef PSUM_ACC_SAT_EN
            if (s > ACC_MAX) begin s = ACC_MAX; sat = 1; end
            if (s < ACC_MIN) begin s = ACC_MIN; sat = 1; end
`endif
          end
          m_acc   = wrap24(s);
          m_cnt   = (q.size() > 63) ? 63 : q.size();
          m_sat   = sat;
          m_valid = 1;
          q.delete();
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (started) begin
      chk("valid", o_Valid, m_valid);
      chk("ready", o_Ready, !(m_valid && !i_Ready));
      chk("acc",   o_Acc,   m_acc);
      chk("count", o_Count, m_cnt);
      chk("err",   o_Err,   m_err);
      chk("sat",   o_Sat,   m_sat);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int p, input int s, input bit l,
                       input bit c, input bit r);
    i_Valid = v;
    i_PSUM  = p[11:0];
    i_Shift = s[2:0];
    i_Last  = l;
    i_Clear = c;
    i_Ready = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_rand();
    int p;
    p = $urandom_range(0, 4095);
    drive(($urandom_range(0, 9) < 7), p - 2048, $urandom_range(0, 7),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 6));
  endtask

  initial begin
    // Reset held two cycles under random input
    RST = 1'b1;
    for (int i = 0; i < 2; i++) drive_rand();
    RST = 1'b0;
    i_Valid = 1'b0;
    chk("rst_valid", o_Valid, 0);
    chk("rst_acc",   o_Acc,   0);
    chk("rst_count", o_Count, 0);
    chk("rst_ready", o_Ready, 1);
    chk("rst_err",   o_Err,   0);

    // Basic three-beat group: 5 - 6 + 28 = 27
    drive(1, 5, 0, 0, 0, 1);
    drive(1, -3, 1, 0, 0, 1);
    drive(1, 7, 2, 1, 0, 1);
    chk("basic_valid", o_Valid, 1);
    chk("basic_acc",   o_Acc,   27);
    chk("basic_count", o_Count, 3);
    drive(0, 0, 0, 0, 0, 1);
    chk("basic_drain", o_Valid, 0);

    // Backpressure
    drive(1, 10, 0, 1, 0, 0);
    chk("bp_first_acc", o_Acc, 10);
    i_Valid = 1; i_PSUM = 12'd1; i_Shift = 3'd0; i_Last = 1; i_Ready = 0;
    #1;
    chk("bp_ready_low", o_Ready, 0);
    @(posedge CLK); #1;
    chk("bp_held_acc",   o_Acc,   10);
    chk("bp_held_valid", o_Valid, 1);
    drive(1, 1, 0, 1, 0, 1);
    chk("bp_new_valid", o_Valid, 1);
    chk("bp_new_acc",   o_Acc,   1);
    chk("bp_new_count", o_Count, 1);
    drive(0, 0, 0, 0, 0, 1);

    // Single-beat group at the most negative input and largest shift
    drive(1, -2048, 7, 1, 0, 1);
    chk("single_acc",   o_Acc,   -262144);
    chk("single_count", o_Count, 1);
    drive(0, 0, 0, 0, 0, 1);

    // Clear mid-group
    drive(1, 100, 0, 0, 0, 1);
    drive(1, 200, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(1, 4, 0, 1, 0, 1);
    chk("clear_acc",   o_Acc,   4);
    chk("clear_count", o_Count, 1);
    drive(0, 0, 0, 0, 0, 1);

    // Accumulator overflow: 33 * 2047 * 128 exceeds the signed 24-bit range
    for (int i = 0; i < 33; i++) drive(1, 2047, 7, (i == 32), 0, 1);
`ifdef PSUM_ACC_SAT_EN
    chk("ovf_acc", o_Acc, 8388607);
    chk("ovf_sat", o_Sat, 1);
`else
    chk("ovf_acc", o_Acc, -8130688);
    chk("ovf_sat", o_Sat, 0);
`endif
    chk("ovf_count", o_Count, 33);
    drive(0, 0, 0, 0, 0, 1);

    // Beat-counter overflow
    for (int i = 0; i < 63; i++) drive(1, 0, 0, 0, 0, 1);
    chk("cnt_no_err", o_Err, 0);
    drive(1, 0, 0, 0, 0, 1);
    chk("cnt_err", o_Err, 1);
    drive(0, 0, 0, 0, 1, 1);
    chk("cnt_err_sticky", o_Err, 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 499) == 0);
      drive_rand();
    end
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
